instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/instr_fetch_if.sv | 13 +
 rtl/if_id_reg.sv | 33 +++
 rtl/instr_fetch.sv | 109 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions.
// Holds the next-PC select encodings, the base opcode values the control
// unit decodes, the canonical bubble instruction, and the IF/ID record type.
package riscv_pkg;

  // Next-PC select driven by the execute stage.
  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,  // sequential fetch
    PCSRC_BRANCH = 2'b01,  // PC-relative target (BEQ/JAL)
    PCSRC_JALR   = 2'b10,  // register-based target
    PCSRC_RSVD   = 2'b11   // reserved, behaves as PCSRC_PLUS4
  } pcsrc_e;

  // Base opcodes, instr[6:0].
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  // addi x0,x0,0: the bubble inserted on a flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Instruction addresses are word aligned; targets drop their low two bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port.
//   imem_addr  : byte address of the word being fetched (fetch side drives)
//   imem_rdata : instruction word, combinational read of imem_addr
// master = fetch unit, slave = instruction memory.
interface instr_fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture din (normal advance)
//   flush      : replace the instruction with a bubble, keep the PC field
//   din / q    : next / current IF/ID contents
// flush wins over load; with neither asserted the register holds.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             flush,
  input  riscv_pkg::ifid_t din,
  output riscv_pkg::ifid_t q
);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      q.pc    <= '0;
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= din;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
//   clk, reset        : clock and synchronous active-high reset
//   pcsrc             : next-PC select (see riscv_pkg::pcsrc_e)
//   br_target         : PC-relative target, used when pcsrc = 01
//   jalr_target       : register target, used when pcsrc = 10
//   stall             : hold PC, IF/ID and fetch_count
//   imem              : instruction-memory read port (addr = current PC)
//   ifid_pc/instr/valid : IF/ID register contents
//   opcode/func3/func7: decode slices of ifid_instr
//   fetch_count       : instructions accepted into IF/ID since reset
// Priority: reset > redirect > stall > advance. A redirect flushes the
// wrong-path word being fetched this cycle, even while stalled.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          pcsrc,
  input  logic [31:0]         br_target,
  input  logic [31:0]         jalr_target,
  input  logic                stall,
  instr_fetch_if.master       imem,
  output logic [31:0]         ifid_pc,
  output logic [31:0]         ifid_instr,
  output logic                ifid_valid,
  output logic [6:0]          opcode,
  output logic [2:0]          func3,
  output logic [6:0]          func7,
  output logic [31:0]         fetch_count
);

  import riscv_pkg::*;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        advance;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path through the block leaves it unassigned (no latch).
  always_comb begin
    redirect        = 1'b0;
    redirect_target = '0;
    case (pcsrc_e'(pcsrc))
      PCSRC_BRANCH: begin
        redirect        = 1'b1;
        redirect_target = br_target;
      end
      PCSRC_JALR: begin
        redirect        = 1'b1;
        redirect_target = jalr_target;
      end
      default: ;  // PLUS4 and RSVD both fall through to sequential fetch
    endcase
  end

  assign advance = !redirect && !stall;

  // PC + 4 wraps naturally at 2^32.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = word_align(redirect_target);
    end else if (advance) begin
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      pc <= pc_next;
      if (advance) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  assign ifid_d = '{pc: pc, instr: imem.imem_rdata, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (advance),
    .flush (redirect),
    .din   (ifid_d),
    .q     (ifid_q)
  );

  assign imem.imem_addr = pc;

  assign ifid_pc    = ifid_q.pc;
  assign ifid_instr = ifid_q.instr;
  assign ifid_valid = ifid_q.valid;

  // Decode fields come only from the registered instruction.
  assign opcode = ifid_q.instr[6:0];
  assign func3  = ifid_q.instr[14:12];
  assign func7  = ifid_q.instr[31:25];

endmodule
